io_bridge_mc: RTL and testbench

IO_BRIDGE_MC -- requirements
Module: io_bridge_mc

---
 rtl/io_bridge_mc.sv | 175 +++++++++++++++++
 tb/tb_io_bridge_mc.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/io_bridge_mc.sv
// io_bridge_mc -- multi-channel FIFO bridge.
//
// NUM_CH independent FIFOs, each holding RAM_DEPTH words, share one write
// port and one read port. The channel is picked per request. Each accepted
// request gives a one-cycle Ack on the following cycle. A read returns its
// word in Data_o with one cycle of latency.
//
// Optional feature: define IO_BRIDGE_MC_ERR_EN to get sticky per-channel
// error flags. A flag sets on a write rejected because its channel is full,
// or on a read rejected because its channel is empty. Without the macro,
// Err_o is tied to 0.
//
// Ports
//   clk      : single clock, rising edge
//   reset    : asynchronous, active-high reset
//   ReqW_i   : write request
//   ChW_i    : write channel select
//   Data_i   : write word
//   ReqR_i   : read request
//   ChR_i    : read channel select
//   AckW_o   : write accepted (one cycle after the request edge)
//   AckR_o   : read accepted; Data_o valid
//   Data_o   : read word; holds its value between reads
//   Full_o   : per-channel full flags
//   Empty_o  : per-channel empty flags
//   Err_o    : per-channel sticky error flags

// Per-channel pointer/occupancy control; storage lives in the parent.
module io_bridge_mc_ch #(
   parameter int ADDR_WIDTH = 6,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_wr,
   input  logic                  i_rd,
   output logic [ADDR_WIDTH-1:0] o_wptr,
   output logic [ADDR_WIDTH-1:0] o_rptr,
   output logic                  o_full,
   output logic                  o_empty
);
   localparam int CNT_W = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic                  r_full, r_empty;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_wr && !i_rd)      w_cnt_nxt = r_cnt + 1'b1;
      else if (!i_wr && i_rd) w_cnt_nxt = r_cnt - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_cnt   <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         // explicit wrap so non-power-of-two depths also work
         if (i_wr) r_wptr <= (r_wptr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
         if (i_rd) r_rptr <= (r_rptr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
         r_cnt   <= w_cnt_nxt;
         // flags track the post-edge count
         r_full  <= (w_cnt_nxt == CNT_W'(RAM_DEPTH));
         r_empty <= (w_cnt_nxt == '0);
      end
   end

   assign o_wptr  = r_wptr;
   assign o_rptr  = r_rptr;
   assign o_full  = r_full;
   assign o_empty = r_empty;
endmodule

module io_bridge_mc #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
   parameter int NUM_CH     = 4,
   parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ReqW_i,
   input  logic [CH_W-1:0]       ChW_i,
   input  logic [DATA_WIDTH-1:0] Data_i,
   input  logic                  ReqR_i,
   input  logic [CH_W-1:0]       ChR_i,
   output logic                  AckW_o,
   output logic                  AckR_o,
   output logic [DATA_WIDTH-1:0] Data_o,
   output logic [NUM_CH-1:0]     Full_o,
   output logic [NUM_CH-1:0]     Empty_o,
   output logic [NUM_CH-1:0]     Err_o
);
   logic [NUM_CH-1:0]                 w_wsel, w_rsel, w_wacc, w_racc;
   logic [NUM_CH-1:0]                 w_full, w_empty;
   logic [NUM_CH-1:0][ADDR_WIDTH-1:0] w_wptr, w_rptr;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_rdata;
   logic [DATA_WIDTH-1:0]             w_rd_word;
   logic                              r_ackw, r_ackr;
   logic [DATA_WIDTH-1:0]             r_data;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

      // An out-of-range channel index matches no c, so it is rejected here.
      assign w_wsel[c] = ReqW_i && (ChW_i == CH_W'(c));
      assign w_rsel[c] = ReqR_i && (ChR_i == CH_W'(c));
      // A read is never served through an empty channel, even with a write.
      assign w_racc[c] = w_rsel[c] && !w_empty[c];
      // A full channel still takes a write when it is read on the same edge.
      assign w_wacc[c] = w_wsel[c] && (!w_full[c] || w_racc[c]);

      // On a full channel, wptr==rptr. The read still sees the old word
      // because the write lands only after the edge.
      always_ff @(posedge clk) begin
         if (w_wacc[c]) r_mem[w_wptr[c]] <= Data_i;
      end
      assign w_rdata[c] = r_mem[w_rptr[c]];

      io_bridge_mc_ch #(
         .ADDR_WIDTH (ADDR_WIDTH),
         .RAM_DEPTH  (RAM_DEPTH)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .i_wr    (w_wacc[c]),
         .i_rd    (w_racc[c]),
         .o_wptr  (w_wptr[c]),
         .o_rptr  (w_rptr[c]),
         .o_full  (w_full[c]),
         .o_empty (w_empty[c])
      );
   end

   // At most one bit of w_racc is set, so this selects that channel's word.
   always_comb begin
      w_rd_word = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (w_racc[c]) w_rd_word = w_rdata[c];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ackw <= 1'b0;
         r_ackr <= 1'b0;
         r_data <= '0;
      end else begin
         r_ackw <= |w_wacc;
         r_ackr <= |w_racc;
         if (|w_racc) r_data <= w_rd_word;
      end
   end

`ifdef IO_BRIDGE_MC_ERR_EN
   logic [NUM_CH-1:0] r_err;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_err <= '0;
      else       r_err <= r_err | (w_wsel & ~w_wacc) | (w_rsel & w_empty);
   end
   assign Err_o = r_err;
`else
   assign Err_o = '0;
`endif

   assign AckW_o  = r_ackw;
   assign AckR_o  = r_ackr;
   assign Data_o  = r_data;
   assign Full_o  = w_full;
   assign Empty_o = w_empty;
endmodule

// File: tb/tb_io_bridge_mc.sv
// Bench for io_bridge_mc. It keeps a per-channel queue model and compares
// every output on each falling edge. Directed scenarios add literal checks,
// and a long randomized run follows them.
module tb_io_bridge_mc;
   localparam int DW = 8, AW = 6, DEPTH = 64, NCH = 4, CW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ReqW_i = 1'b0, ReqR_i = 1'b0;
   logic [CW-1:0] ChW_i = '0, ChR_i = '0;
   logic [DW-1:0] Data_i = '0;
   logic          AckW_o, AckR_o;
   logic [DW-1:0] Data_o;
   logic [NCH-1:0] Full_o, Empty_o, Err_o;

   int n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   io_bridge_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .NUM_CH(NCH), .CH_W(CW)) dut (
      .clk(clk), .reset(reset),
      .ReqW_i(ReqW_i), .ChW_i(ChW_i), .Data_i(Data_i),
      .ReqR_i(ReqR_i), .ChR_i(ChR_i),
      .AckW_o(AckW_o), .AckR_o(AckR_o), .Data_o(Data_o),
      .Full_o(Full_o), .Empty_o(Empty_o), .Err_o(Err_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0]  q [NCH][$];
   logic           exp_ackw = 1'b0, exp_ackr = 1'b0;
   logic [DW-1:0]  exp_data = '0;
   logic [NCH-1:0] exp_err = '0;
   logic           m_wacc, m_racc;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++) q[c].delete();
         exp_ackw = 1'b0;
         exp_ackr = 1'b0;
         exp_data = '0;
         exp_err  = '0;
      end else begin
         m_racc = ReqR_i && (q[ChR_i].size() > 0);
         m_wacc = ReqW_i && ((q[ChW_i].size() < DEPTH) || (m_racc && ChR_i == ChW_i));
         exp_ackw = m_wacc;
         exp_ackr = m_racc;
         if (m_racc) exp_data = q[ChR_i].pop_front();
         if (m_wacc) q[ChW_i].push_back(Data_i);
`ifdef IO_BRIDGE_MC_ERR_EN
         if (ReqW_i && !m_wacc) exp_err[ChW_i] = 1'b1;
         if (ReqR_i && !m_racc) exp_err[ChR_i] = 1'b1;
`endif
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      logic [NCH-1:0] ef, ee;
      for (int c = 0; c < NCH; c++) begin
         ef[c] = (q[c].size() == DEPTH);
         ee[c] = (q[c].size() == 0);
      end
      chk("ackw",  32'(AckW_o),  32'(exp_ackw));
      chk("ackr",  32'(AckR_o),  32'(exp_ackr));
      chk("data",  32'(Data_o),  32'(exp_data));
      chk("full",  32'(Full_o),  32'(ef));
      chk("empty", 32'(Empty_o), 32'(ee));
      chk("err",   32'(Err_o),   32'(exp_err));
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic w, input logic [CW-1:0] cw, input logic [DW-1:0] d,
                        input logic r, input logic [CW-1:0] cr);
      ReqW_i = w; ChW_i = cw; Data_i = d; ReqR_i = r; ChR_i = cr;
      @(negedge clk);
      ReqW_i = 1'b0; ReqR_i = 1'b0;
   endtask

   initial begin
      int pw, pr;
      // reset state
      @(negedge clk); @(negedge clk);
      chk("rst_ackw", 32'(AckW_o), 32'h0);
      chk("rst_ackr", 32'(AckR_o), 32'h0);
      chk("rst_data", 32'(Data_o), 32'h0);
      chk("rst_full", 32'(Full_o), 32'h0);
      chk("rst_empty", 32'(Empty_o), 32'hF);
      chk("rst_err", 32'(Err_o), 32'h0);
      #2 reset = 1'b0;

      // write 0xA5 to ch0 on the first edge out of reset, then read it back
      drive(1'b1, 2'd0, 8'hA5, 1'b0, 2'd0);
      chk("t36_ackw", 32'(AckW_o), 32'h1);
      drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
      chk("t36_ackr", 32'(AckR_o), 32'h1);
      chk("t36_data", 32'(Data_o), 32'hA5);
      chk("t36_empty0", 32'(Empty_o[0]), 32'h1);

      // fill ch2, overflow it once, then drain it in order
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 2'd2, DW'(i), 1'b0, 2'd0);
      drive(1'b1, 2'd2, 8'hEE, 1'b0, 2'd0);
      chk("t37_ackw", 32'(AckW_o), 32'h0);
      chk("t37_full2", 32'(Full_o[2]), 32'h1);
`ifdef IO_BRIDGE_MC_ERR_EN
      chk("t37_err2", 32'(Err_o[2]), 32'h1);
`endif
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
         chk("t37_rd", 32'(Data_o), 32'(i));
      end

      // read an empty ch1 while writing it: only the write is accepted
      drive(1'b1, 2'd1, 8'h3C, 1'b1, 2'd1);
      chk("t38_ackw", 32'(AckW_o), 32'h1);
      chk("t38_ackr", 32'(AckR_o), 32'h0);
      drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
      chk("t38_data", 32'(Data_o), 32'h3C);

      // fill ch3, then write and read it together while full
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 2'd3, DW'(i), 1'b0, 2'd0);
      drive(1'b1, 2'd3, 8'h77, 1'b1, 2'd3);
      chk("t39_ackw", 32'(AckW_o), 32'h1);
      chk("t39_ackr", 32'(AckR_o), 32'h1);
      chk("t39_data", 32'(Data_o), 32'h0);
      chk("t39_full3", 32'(Full_o[3]), 32'h1);
      for (int i = 0; i < DEPTH; i++) drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
      chk("t39_last", 32'(Data_o), 32'h77);

      // reset with ch0 holding five words
      for (int i = 0; i < 5; i++) drive(1'b1, 2'd0, DW'(8'h10 + i), 1'b0, 2'd0);
      #2 reset = 1'b1;
      #1;
      chk("t40_ackw", 32'(AckW_o), 32'h0);
      chk("t40_ackr", 32'(AckR_o), 32'h0);
      chk("t40_data", 32'(Data_o), 32'h0);
      chk("t40_full", 32'(Full_o), 32'h0);
      chk("t40_empty", 32'(Empty_o), 32'hF);
      chk("t40_err", 32'(Err_o), 32'h0);
      @(negedge clk);
      #2 reset = 1'b0;
      drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
      chk("t40_noackr", 32'(AckR_o), 32'h0);

      // randomized traffic, with write/read bias varied per block
      for (int b = 0; b < 50; b++) begin
         pw = $urandom_range(90, 10);
         pr = $urandom_range(90, 10);
         for (int i = 0; i < 1000; i++)
            drive($urandom_range(99) < pw, CW'($urandom_range(NCH - 1)), DW'($urandom),
                  $urandom_range(99) < pr, CW'($urandom_range(NCH - 1)));
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
